wave_classifier: RTL and testbench
==================================

Name: wave_classifier

Overview:
- Receive end of the 5-bit waveform generator interface: consumes a sampled wave stream and identifies the waveform as square, sawtooth or triangle.
- Measures the period in valid samples and reports lock and error status.
- Sits downstream of the signal generator, or of an ADC front end, in the waveform test subsystem.

Parameters:
SAMPLE_W, 5, sample width
MAX_LEVEL, 20, peak level of all waveforms
PERIOD_W, 8, width of period counter/output

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
sample_valid  in  1  sample qualifier; all state holds when low
sample  in  SAMPLE_W  wave sample
wave_type  out  2  0=square 1=sawtooth 2=triangle 3=none; matches generator wave_choise
locked  out  1  classification and period valid
period  out  PERIOD_W  samples per period of locked waveform
err_pulse  out  1  one-cycle pulse on lock loss or out-of-range sample

Behaviour:
- Reset: wave_type=3, locked=0, period=0, err_pulse=0; FSM=EMPTY; cand_mask=3'b111; counter=0.
- All outputs registered. A response appears the cycle after the qualifying valid sample.
- FSM states:
  - EMPTY: no previous sample held.
  - ACQ: narrowing cand_mask / counting anchors.
  - LOCKED.
- EMPTY: on a valid sample, store prev=sample and go to ACQ.
- Each valid sample in ACQ/LOCKED computes d = sample - prev as a signed 6-bit value. Compatibility:
  - square: d in {0, +20, -20}
  - sawtooth: d in {+1, -20}
  - triangle: d in {+1, -1}
- sample > MAX_LEVEL is compatible with nothing.
- cand_mask_next = cand_mask & compat. Then prev <= sample.
- Anchors are counted only while cand_mask_next is one-hot:
  - square: d=+20
  - sawtooth: d=-20
  - triangle: sample==20 with d=+1
- Period counter: cleared at each anchor, +1 on each other valid sample, saturates at all-ones. At an anchor, measured period = counter+1.
- ACQ:
  - mask_next zero: mask <= 111, anchor count <= 0, stay ACQ (prev=sample). err_pulse only if the sample is out of range.
  - second counted anchor: period <= measured, wave_type <= resolved type, locked <= 1, go LOCKED.
- LOCKED:
  - Compatible sample: stay locked.
  - Each anchor updates period.
  - Incompatible sample, or counter saturation: err_pulse=1, locked=0, wave_type=3, period held, mask <= 111, anchors=0, go ACQ.
  - Out-of-range sample: also prev <= 0, go EMPTY.
- Counter saturation in ACQ: restart acquisition silently.
- sample_valid low: no state change, err_pulse=0.
- Async reset mid-operation: immediate return to reset values.

Optional Feature:
- Macro WAVE_CLASSIFIER_AMPL_EN.
- Defined:
  - Adds outputs amp_min and amp_max, each SAMPLE_W wide, reset 0.
  - Running min/max are tracked between anchors. At each anchor while locked, they are latched to the outputs and the trackers restart from the current sample.
  - On lock loss, the outputs clear to 0.
- Undefined: ports and trackers absent; remaining behaviour identical.

Decomposition:
- Package wave_pkg: wave_type encoding constants (SQUARE=0, SAW=1, TRI=2, NONE=3), MAX_LEVEL, FSM state encoding, compat mask bit positions.
- One combinational sub-module, wave_delta_check: inputs prev and sample; outputs signed delta, 3-bit compat mask, out_of_range flag.

Test Plan:
- Square, period 20 (10×0 then 10×20, repeated): first d=0 resolves square; locked=1, wave_type=0, period=20 the cycle after the second 0→20 edge.
- Sawtooth 0..20 repeated: mask holds {saw,tri} until first wrap; lock after second wrap, wave_type=1, period=21.
- Triangle 0→20→0 repeated: resolves at first d=-1; lock at third peak (sample index 100), wave_type=2, period=40.
- Lock loss: locked on sawtooth, inject 7 after 3:
  - Next cycle: err_pulse=1 for 1 cycle, locked=0, wave_type=3.
  - Re-lock with period=21 after two further wraps.
- Out of range: sample=25 while locked on square → err_pulse=1, state EMPTY; re-lock needs full acquisition. Same sample in ACQ → err_pulse=1, no lock.
- sample_valid gaps and reset: random valid-low bubbles in the triangle stream leave period=40 and lock time unchanged in valid-sample count. Asserting rst_n=0 while locked clears all outputs asynchronously.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared encodings for the waveform classifier: wave_type codes, FSM states,
// compat-mask bit positions and a one-hot mask to wave_type decoder.
package wave_pkg;

    localparam int MAX_LEVEL = 20;

    localparam logic [1:0] WT_SQUARE = 2'd0;
    localparam logic [1:0] WT_SAW    = 2'd1;
    localparam logic [1:0] WT_TRI    = 2'd2;
    localparam logic [1:0] WT_NONE   = 2'd3;

    // Compat bit positions line up with the wave_type codes
    localparam int CM_SQ  = 0;
    localparam int CM_SAW = 1;
    localparam int CM_TRI = 2;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic logic [1:0] mask_to_type(input logic [2:0] mask);
        logic [1:0] wt;
        wt = WT_NONE;
        case (mask)
            3'b001:  wt = WT_SQUARE;
            3'b010:  wt = WT_SAW;
            3'b100:  wt = WT_TRI;
            default: wt = WT_NONE;
        endcase
        return wt;
    endfunction

endpackage

// File: rtl/wave_delta_check.sv
// Combinational step check: signed delta between consecutive samples and which
// waveform shapes that step is consistent with.
module wave_delta_check #(
    parameter int SAMPLE_W  = 5,
    parameter int MAX_LEVEL = 20
) (
    input  logic [SAMPLE_W-1:0] prev,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [SAMPLE_W:0]   delta,
    output logic [2:0]          compat,
    output logic                out_of_range
);
    import wave_pkg::*;

    localparam logic signed [SAMPLE_W:0] PEAK = (SAMPLE_W+1)'(MAX_LEVEL);
    localparam logic signed [SAMPLE_W:0] ONE  = (SAMPLE_W+1)'(1);

    logic signed [SAMPLE_W:0] d;

    always_comb begin
        d            = $signed({1'b0, sample}) - $signed({1'b0, prev});
        out_of_range = (sample > SAMPLE_W'(MAX_LEVEL));
        compat       = 3'b000;
        compat[CM_SQ]  = (d == '0) || (d == PEAK) || (d == -PEAK);
        compat[CM_SAW] = (d == ONE) || (d == -PEAK);
        compat[CM_TRI] = (d == ONE) || (d == -ONE);
        if (out_of_range) compat = 3'b000;
        delta = d;
    end

endmodule

// File: rtl/wave_classifier.sv
// Waveform classifier: narrows square/sawtooth/triangle candidates from sample
// steps, measures the period between anchors and locks after two anchors.
// Optional amplitude min/max outputs when WAVE_CLASSIFIER_AMPL_EN is defined.
module wave_classifier #(
    parameter int SAMPLE_W  = 5,
    parameter int MAX_LEVEL = 20,
    parameter int PERIOD_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [1:0]          wave_type,
    output logic                locked,
    output logic [PERIOD_W-1:0] period,
`ifdef WAVE_CLASSIFIER_AMPL_EN
    output logic [SAMPLE_W-1:0] amp_min,
    output logic [SAMPLE_W-1:0] amp_max,
`endif
    output logic                err_pulse
);
    import wave_pkg::*;

    localparam logic signed [SAMPLE_W:0] PEAK = (SAMPLE_W+1)'(MAX_LEVEL);
    localparam logic signed [SAMPLE_W:0] ONE  = (SAMPLE_W+1)'(1);

    state_t              state_q, state_d;
    logic [SAMPLE_W-1:0] prev_q, prev_d;
    logic [2:0]          mask_q, mask_d;
    logic                anchors_q, anchors_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [1:0]          wave_type_q, wave_type_d;
    logic                locked_q, locked_d;
    logic                err_q, err_d;

    logic [SAMPLE_W:0]   delta;
    logic [2:0]          compat;
    logic                out_of_range;
    logic [2:0]          mask_next;
    logic                one_hot;
    logic                is_anchor;
    logic                cnt_sat;
    logic [PERIOD_W-1:0] cnt_inc;
    logic [PERIOD_W-1:0] measured;
    logic                active;
    logic                lose_lock;
    logic                lock_anchor;

    wave_delta_check #(
        .SAMPLE_W  (SAMPLE_W),
        .MAX_LEVEL (MAX_LEVEL)
    ) u_delta (
        .prev         (prev_q),
        .sample       (sample),
        .delta        (delta),
        .compat       (compat),
        .out_of_range (out_of_range)
    );

    always_comb begin
        mask_next = mask_q & compat;
        one_hot   = (mask_next != 3'b000) && ((mask_next & (mask_next - 3'd1)) == 3'b000);
        is_anchor = one_hot &&
                    ((mask_next[CM_SQ]  && ($signed(delta) == PEAK)) ||
                     (mask_next[CM_SAW] && ($signed(delta) == -PEAK)) ||
                     (mask_next[CM_TRI] && ($signed(delta) == ONE) &&
                      (sample == SAMPLE_W'(MAX_LEVEL))));
        cnt_sat   = (cnt_q == '1) && !is_anchor;
        cnt_inc   = cnt_sat ? cnt_q : cnt_q + 1'b1;
        measured  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        active    = sample_valid && (state_q != ST_EMPTY);
        lose_lock = active && (state_q == ST_LOCKED) &&
                    ((mask_next == 3'b000) || cnt_sat);
        // Second anchor in ACQ acquires lock; every anchor in LOCKED refreshes it
        lock_anchor = active && is_anchor &&
                      ((state_q == ST_LOCKED) || anchors_q);
    end

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        mask_d      = mask_q;
        anchors_d   = anchors_q;
        cnt_d       = cnt_q;
        period_d    = period_q;
        wave_type_d = wave_type_q;
        locked_d    = locked_q;
        err_d       = 1'b0;

        if (sample_valid) begin
            case (state_q)
                ST_EMPTY: begin
                    if (out_of_range) begin
                        err_d = 1'b1;
                    end else begin
                        prev_d  = sample;
                        cnt_d   = '0;
                        state_d = ST_ACQ;
                    end
                end
                ST_LOCKED: begin
                    prev_d = sample;
                    cnt_d  = is_anchor ? '0 : cnt_inc;
                    if (lose_lock) begin
                        err_d       = 1'b1;
                        locked_d    = 1'b0;
                        wave_type_d = WT_NONE;
                        mask_d      = 3'b111;
                        anchors_d   = 1'b0;
                        state_d     = ST_ACQ;
                        if (cnt_sat) cnt_d = '0;
                        if (out_of_range) begin
                            prev_d  = '0;
                            cnt_d   = '0;
                            state_d = ST_EMPTY;
                        end
                    end else if (is_anchor) begin
                        period_d = measured;
                    end
                end
                default: begin
                    prev_d = sample;
                    cnt_d  = is_anchor ? '0 : cnt_inc;
                    if ((mask_next == 3'b000) || cnt_sat) begin
                        // Restart; clearing a saturated counter avoids re-tripping forever
                        mask_d    = 3'b111;
                        anchors_d = 1'b0;
                        err_d     = out_of_range;
                        if (cnt_sat) cnt_d = '0;
                    end else begin
                        mask_d = mask_next;
                        if (lock_anchor) begin
                            period_d    = measured;
                            wave_type_d = mask_to_type(mask_next);
                            locked_d    = 1'b1;
                            anchors_d   = 1'b0;
                            state_d     = ST_LOCKED;
                        end else if (is_anchor) begin
                            anchors_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            prev_q      <= '0;
            mask_q      <= 3'b111;
            anchors_q   <= 1'b0;
            cnt_q       <= '0;
            period_q    <= '0;
            wave_type_q <= WT_NONE;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            mask_q      <= mask_d;
            anchors_q   <= anchors_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            wave_type_q <= wave_type_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
        end
    end

    assign wave_type = wave_type_q;
    assign locked    = locked_q;
    assign period    = period_q;
    assign err_pulse = err_q;

`ifdef WAVE_CLASSIFIER_AMPL_EN
    logic [SAMPLE_W-1:0] trk_min_q, trk_min_d;
    logic [SAMPLE_W-1:0] trk_max_q, trk_max_d;
    logic [SAMPLE_W-1:0] amp_min_q, amp_min_d;
    logic [SAMPLE_W-1:0] amp_max_q, amp_max_d;

    // Trackers span anchor to anchor; outputs take the span that just closed
    always_comb begin
        trk_min_d = trk_min_q;
        trk_max_d = trk_max_q;
        amp_min_d = amp_min_q;
        amp_max_d = amp_max_q;
        if (sample_valid && !out_of_range) begin
            if (!active || is_anchor) begin
                trk_min_d = sample;
                trk_max_d = sample;
            end else begin
                if (sample < trk_min_q) trk_min_d = sample;
                if (sample > trk_max_q) trk_max_d = sample;
            end
        end
        if (lose_lock) begin
            amp_min_d = '0;
            amp_max_d = '0;
        end else if (lock_anchor) begin
            amp_min_d = trk_min_q;
            amp_max_d = trk_max_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_min_q <= '0;
            trk_max_q <= '0;
            amp_min_q <= '0;
            amp_max_q <= '0;
        end else begin
            trk_min_q <= trk_min_d;
            trk_max_q <= trk_max_d;
            amp_min_q <= amp_min_d;
            amp_max_q <= amp_max_d;
        end
    end

    assign amp_min = amp_min_q;
    assign amp_max = amp_max_q;
`endif

endmodule

// File: tb/tb_wave_classifier.sv
// Directed bench for wave_classifier: square/sawtooth/triangle lock, lock loss,
// out-of-range handling, valid bubbles and asynchronous reset.
module tb_wave_classifier;

    logic       clk;
    logic       rst_n;
    logic       sample_valid;
    logic [4:0] sample;
    logic [1:0] wave_type;
    logic       locked;
    logic [7:0] period;
    logic       err_pulse;
`ifdef WAVE_CLASSIFIER_AMPL_EN
    logic [4:0] amp_min;
    logic [4:0] amp_max;
`endif

    int total = 0;
    int bad   = 0;

    wave_classifier dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .wave_type    (wave_type),
        .locked       (locked),
        .period       (period),
`ifdef WAVE_CLASSIFIER_AMPL_EN
        .amp_min      (amp_min),
        .amp_max      (amp_max),
`endif
        .err_pulse    (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] sq_s(input int k);
        return ((k % 20) < 10) ? 5'd0 : 5'd20;
    endfunction

    function automatic logic [4:0] saw_s(input int k);
        return 5'(k % 21);
    endfunction

    function automatic logic [4:0] tri_s(input int k);
        int m;
        m = k % 40;
        return (m <= 20) ? 5'(m) : 5'(40 - m);
    endfunction

    // Outputs are sampled 1ns after the edge that consumed the sample
    task automatic send(input logic v, input logic [4:0] s);
        @(negedge clk);
        sample_valid = v;
        sample       = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (wave_type !== 2'd3) begin bad++; $display("FAIL reset_wave_type got=%0d exp=3", wave_type); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%0b exp=0", locked); end
        total++; if (period !== 8'd0) begin bad++; $display("FAIL reset_period got=%0d exp=0", period); end
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", err_pulse); end
    endtask

    task automatic test_square();
        do_reset();
        for (int k = 0; k < 30; k++) send(1'b1, sq_s(k));
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL sq_early_lock got=%0b exp=0", locked); end
        send(1'b1, sq_s(30));
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL sq_locked got=%0b exp=1", locked); end
        total++; if (wave_type !== 2'd0) begin bad++; $display("FAIL sq_type got=%0d exp=0", wave_type); end
        total++; if (period !== 8'd20) begin bad++; $display("FAIL sq_period got=%0d exp=20", period); end
        for (int k = 31; k <= 50; k++) send(1'b1, sq_s(k));
        total++; if (locked !== 1'b1 || period !== 8'd20 || err_pulse !== 1'b0) begin
            bad++; $display("FAIL sq_hold locked=%0b period=%0d err=%0b exp 1/20/0", locked, period, err_pulse);
        end
    endtask

    task automatic test_sawtooth();
        do_reset();
        for (int k = 0; k < 42; k++) send(1'b1, saw_s(k));
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL saw_early_lock got=%0b exp=0", locked); end
        send(1'b1, saw_s(42));
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL saw_locked got=%0b exp=1", locked); end
        total++; if (wave_type !== 2'd1) begin bad++; $display("FAIL saw_type got=%0d exp=1", wave_type); end
        total++; if (period !== 8'd21) begin bad++; $display("FAIL saw_period got=%0d exp=21", period); end
    endtask

    // Continues from a sawtooth lock that ended on the value 0
    task automatic test_lock_loss();
        send(1'b1, 5'd1);
        send(1'b1, 5'd2);
        send(1'b1, 5'd3);
        send(1'b1, 5'd7);
        total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL loss_err got=%0b exp=1", err_pulse); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL loss_locked got=%0b exp=0", locked); end
        total++; if (wave_type !== 2'd3) begin bad++; $display("FAIL loss_type got=%0d exp=3", wave_type); end
        total++; if (period !== 8'd21) begin bad++; $display("FAIL loss_period_held got=%0d exp=21", period); end
        send(1'b1, 5'd4);
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL loss_err_one_cycle got=%0b exp=0", err_pulse); end
        for (int v = 5; v <= 20; v++) send(1'b1, 5'(v));
        send(1'b1, 5'd0);
        for (int v = 1; v <= 20; v++) send(1'b1, 5'(v));
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL relock_early got=%0b exp=0", locked); end
        send(1'b1, 5'd0);
        total++; if (locked !== 1'b1 || period !== 8'd21 || wave_type !== 2'd1) begin
            bad++; $display("FAIL relock locked=%0b period=%0d type=%0d exp 1/21/1", locked, period, wave_type);
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        for (int k = 0; k <= 30; k++) send(1'b1, sq_s(k));
        send(1'b1, 5'd25);
        total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL oor_lock_err got=%0b exp=1", err_pulse); end
        total++; if (locked !== 1'b0 || wave_type !== 2'd3) begin
            bad++; $display("FAIL oor_lock_drop locked=%0b type=%0d exp 0/3", locked, wave_type);
        end
        total++; if (period !== 8'd20) begin bad++; $display("FAIL oor_period_held got=%0d exp=20", period); end
        send(1'b1, sq_s(31));
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL oor_err_one_cycle got=%0b exp=0", err_pulse); end
        for (int k = 32; k < 70; k++) send(1'b1, sq_s(k));
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL oor_relock_early got=%0b exp=0", locked); end
        send(1'b1, sq_s(70));
        total++; if (locked !== 1'b1 || period !== 8'd20) begin
            bad++; $display("FAIL oor_relock locked=%0b period=%0d exp 1/20", locked, period);
        end
        do_reset();
        send(1'b1, 5'd0);
        send(1'b1, 5'd0);
        send(1'b1, 5'd25);
        total++; if (err_pulse !== 1'b1 || locked !== 1'b0) begin
            bad++; $display("FAIL oor_acq err=%0b locked=%0b exp 1/0", err_pulse, locked);
        end
        send(1'b1, 5'd0);
        total++; if (err_pulse !== 1'b0 || wave_type !== 2'd3) begin
            bad++; $display("FAIL oor_acq_after err=%0b type=%0d exp 0/3", err_pulse, wave_type);
        end
    endtask

    task automatic test_gaps();
        int nb;
        do_reset();
        nb = 0;
        for (int k = 0; k < 100; k++) begin
            send(1'b1, tri_s(k));
            if (k % 5 == 2) begin
                repeat ($urandom_range(1, 3)) begin
                    send(1'b0, 5'd31);
                    if (err_pulse !== 1'b0) nb++;
                end
            end
        end
        total++; if (nb != 0) begin bad++; $display("FAIL gap_err_pulses got=%0d exp=0", nb); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL tri_early_lock got=%0b exp=0", locked); end
        send(1'b1, tri_s(100));
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL tri_locked got=%0b exp=1", locked); end
        total++; if (wave_type !== 2'd2) begin bad++; $display("FAIL tri_type got=%0d exp=2", wave_type); end
        total++; if (period !== 8'd40) begin bad++; $display("FAIL tri_period got=%0d exp=40", period); end
        send(1'b0, 5'd31);
        send(1'b0, 5'd7);
        total++; if (locked !== 1'b1 || period !== 8'd40 || err_pulse !== 1'b0) begin
            bad++; $display("FAIL tri_bubble_hold locked=%0b period=%0d err=%0b exp 1/40/0", locked, period, err_pulse);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (locked !== 1'b0 || wave_type !== 2'd3 || period !== 8'd0 || err_pulse !== 1'b0) begin
            bad++; $display("FAIL async_reset locked=%0b type=%0d period=%0d err=%0b exp 0/3/0/0",
                            locked, wave_type, period, err_pulse);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
        test_reset();
        test_square();
        test_sawtooth();
        test_lock_loss();
        test_out_of_range();
        test_gaps();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
